led_matrix_scan: RTL and testbench
==================================

# led_matrix_scan

Refresh engine for the 16×16 LED dot-matrix on the clock board, placed directly downstream of the 16-bit row-pattern PIO. Software writes one 16-bit row pattern per line into a back buffer. The block scans the front buffer line by line with a blanking gap between lines to suppress ghosting. Buffers swap only at a frame boundary on request, so the display never tears.

## Interface
Parameters:
- LINE_CYC, 3000: clk cycles each line is lit (SHOW phase); must be ≥1.
- BLANK_CYC, 125: clk cycles of blanking before each line; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  single-cycle write strobe into the back buffer.
- wr_line  in  4  line index for the write.
- wr_data  in  16  row pattern for that line, driven from the row PIO out_port; bit i = pixel i, 1 = on.
- swap_req  in  1  pulse requesting a front/back swap.
- swap_ack  out  1  one-cycle pulse on the cycle the swap executes.
- frame_start  out  1  one-cycle pulse on the first SHOW cycle of line 0.
- line_sel  out  16  line enables, one-hot active-low; 16'hFFFF = all off.
- row_drv  out  16  pixel drive for the lit line, active-high.

## Operation
- Storage: two banks of 16×16 bits, plus a bank-select bit `front`. Writes always go to bank `!front`; the scan always reads bank `front`.
- FSM, two states:
  - BLANK: line_sel = 16'hFFFF, row_drv = 0. Lasts BLANK_CYC cycles, then goes to SHOW.
  - SHOW: line_sel = ~(1 << line), row_drv = front[line]. Lasts LINE_CYC cycles, then goes to BLANK with line = line + 1 mod 16.
- A single phase counter is reloaded on every state change.
- swap_req sets swap_pending.
- Swap execution: on the SHOW→BLANK transition out of line 15, if swap_pending is set:
  - `front` toggles;
  - swap_ack pulses;
  - swap_pending clears.
- Simultaneous events:
  - swap_req in the swap cycle: the swap executes and swap_pending stays set, so the new request is served at the next frame end.
  - wr_en in the swap cycle: the write lands in the pre-swap back bank, which becomes the new front.
  - Writes to the line currently being shown affect only the back bank, never the lit line.
- Repeated swap_req while pending: absorbed; one swap results.
- Reset (any time, including mid-line):
  - both banks = 0; front = 0; swap_pending = 0;
  - state = BLANK, line = 0, counter reloaded;
  - line_sel = 16'hFFFF, row_drv = 0, swap_ack = 0, frame_start = 0.

## Timing
- All outputs are registered. line_sel and row_drv change on the same clock edge, so no partial-line glitch.
- Line period = BLANK_CYC + LINE_CYC cycles. Frame period = 16 × line period. After reset release, the first SHOW of line 0 begins BLANK_CYC cycles after the first active edge.
- Write latency: data written at edge n is visible on row_drv no earlier than the first SHOW after the next swap.
- Swap latency: from swap_req to swap_ack is at most one frame period plus one cycle.
- frame_start is coincident with the first cycle where line_sel = 16'hFFFE.
- Counter width: $clog2(max(LINE_CYC, BLANK_CYC) + 1).

## Structure
- Package matrix_pkg holds:
  - NUM_LINES = 16, LINE_IDX_W = 4, ROW_W = 16;
  - scan state enum {S_BLANK, S_SHOW};
  - LINE_OFF = 16'hFFFF.
- Sub-module frame_bank: 2×16×16 register array with one write port (bank, line, data, en) and one combinational read port (bank, line). It has an async clear and resets to zero.
- Top level holds the FSM, counter, line index, swap logic and output registers.

## Test plan
All scenarios use LINE_CYC=4, BLANK_CYC=2.
- Reset, then run 2 frames with no writes → line_sel steps FFFE, FFFD … 7FFF with FFFF for 2 cycles between lines. Each line shows for 4 cycles, row_drv is always 0, and frame_start recurs every 96 cycles.
- Write lines 0..15 = 16'h0001 << i, then swap_req → swap_ack fires at the end of line 15. In the next frame, row_drv = 0001 while line_sel = FFFE, and 8000 while line_sel = 7FFF.
- Write line 3 = A5A5 with no swap_req for 3 frames → row_drv stays 0 on line 3. After a swap it shows A5A5.
- swap_req asserted in the same cycle as swap_ack, plus a wr_en (line 0 = 00FF) in that cycle → the swap happens, a second swap_ack follows exactly 96 cycles later, and line 0 shows 00FF in the frame between the two swaps.
- Three swap_req pulses within one frame → exactly one swap_ack.
- reset_n asserted during SHOW of line 7 → asynchronously line_sel = FFFF, row_drv = 0, and banks clear. After release, scanning restarts at line 0 after 2 blank cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, scan state encoding and line-enable helper for the
// 16x16 LED matrix refresh engine.
package matrix_pkg;

  localparam int NUM_LINES  = 16;
  localparam int LINE_IDX_W = 4;
  localparam int ROW_W      = 16;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [ROW_W-1:0]      LINE_OFF  = 16'hFFFF;
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = 4'd15;

  // One-hot active-low enable for a single matrix line.
  function automatic logic [ROW_W-1:0] line_enable(input logic [LINE_IDX_W-1:0] line);
    logic [ROW_W-1:0] one;
    one = 16'h0001;
    return ~(one << line);
  endfunction

endpackage

// File: rtl/frame_bank.sv
// Double-buffered frame store: two banks of 16 lines x 16 pixels, one write
// port and one combinational read port. Asynchronously cleared to all-off.
module frame_bank
  import matrix_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [LINE_IDX_W-1:0] wr_line,
  input  logic [ROW_W-1:0]      wr_data,
  input  logic                  rd_bank,
  input  logic [LINE_IDX_W-1:0] rd_line,
  output logic [ROW_W-1:0]      rd_data
);

  logic [ROW_W-1:0] mem_q [2][NUM_LINES];
  logic [ROW_W-1:0] mem_d [2][NUM_LINES];

  // Next contents: apply the single write, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_bank][wr_line] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage registers with asynchronous clear to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < NUM_LINES; l++) begin
          mem_q[b][l] <= {ROW_W{1'b0}};
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_bank][rd_line];

endmodule

// File: rtl/led_matrix_scan.sv
// LED matrix refresh engine: scans the front bank line by line with a
// blanking gap before each line, and swaps front/back only at frame end.
module led_matrix_scan
  import matrix_pkg::*;
#(
  parameter int LINE_CYC  = 3000,
  parameter int BLANK_CYC = 125
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [LINE_IDX_W-1:0] wr_line,
  input  logic [ROW_W-1:0]      wr_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_start,
  output logic [ROW_W-1:0]      line_sel,
  output logic [ROW_W-1:0]      row_drv
);

  localparam int CNT_MAX = (LINE_CYC > BLANK_CYC) ? LINE_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LINE_RELOAD  = CNT_W'(LINE_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_IDX_W-1:0]   line_q, line_d;
  logic                    front_q, front_d;
  logic                    pending_q, pending_d;
  logic                    started_q, started_d;
  logic                    swap_ack_q, swap_ack_d;
  logic                    frame_start_q, frame_start_d;
  logic [ROW_W-1:0]        line_sel_q, line_sel_d;
  logic [ROW_W-1:0]        row_drv_q, row_drv_d;
  logic [ROW_W-1:0]        rd_data_s;

  // Writes always target the back bank; the scan reads the front bank at the
  // line about to be shown so row_drv is registered alongside line_sel.
  frame_bank u_frame_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_bank (~front_q),
    .wr_line (wr_line),
    .wr_data (wr_data),
    .rd_bank (front_q),
    .rd_line (line_d),
    .rd_data (rd_data_s)
  );

  // Scan sequencing: phase counter, line index and frame-end swap.
  // The first edge after reset only arms the sequencer, so the reset period
  // itself does not eat into the opening blank gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    front_d   = front_q;
    pending_d = pending_q | swap_req;
    started_d = 1'b1;
    if (!started_q) begin
      cnt_d = cnt_q;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = S_SHOW;
            cnt_d   = LINE_RELOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = S_BLANK;
            cnt_d   = BLANK_RELOAD;
            line_d  = line_q + LINE_IDX_W'(1);
            if ((line_q == LAST_LINE) && pending_q) begin
              // A request arriving in the swap cycle stays pending for the next frame.
              front_d   = ~front_q;
              pending_d = swap_req;
            end else begin
              front_d = front_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_BLANK;
          cnt_d   = BLANK_RELOAD;
        end
      endcase
    end
  end

  // Output decode from the next state so every output register lines up with
  // the state register (swap_ack is high in the cycle whose edge swaps).
  always_comb begin
    swap_ack_d    = (state_d == S_SHOW) && (cnt_d == CNT_ZERO) &&
                    (line_d == LAST_LINE) && pending_d;
    frame_start_d = (state_q == S_BLANK) && (state_d == S_SHOW) &&
                    (line_d == {LINE_IDX_W{1'b0}});
    if (state_d == S_SHOW) begin
      line_sel_d = line_enable(line_d);
      row_drv_d  = rd_data_s;
    end else begin
      line_sel_d = LINE_OFF;
      row_drv_d  = {ROW_W{1'b0}};
    end
  end

  // State and output registers, asynchronously reset to the blanked state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_BLANK;
      cnt_q         <= BLANK_RELOAD;
      line_q        <= {LINE_IDX_W{1'b0}};
      front_q       <= 1'b0;
      pending_q     <= 1'b0;
      started_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      line_sel_q    <= LINE_OFF;
      row_drv_q     <= {ROW_W{1'b0}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      front_q       <= front_d;
      pending_q     <= pending_d;
      started_q     <= started_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      line_sel_q    <= line_sel_d;
      row_drv_q     <= row_drv_d;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign line_sel    = line_sel_q;
  assign row_drv     = row_drv_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan with LINE_CYC=4, BLANK_CYC=2.
// A time-indexed reference model pushes expected outputs into a scoreboard
// each cycle; they are popped and compared after the following clock edge.
module tb_led_matrix_scan;

  localparam int LC = 4;
  localparam int BC = 2;
  localparam int LP = LC + BC;
  localparam int FP = 16 * LP;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_line;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_ack;
  logic        frame_start;
  logic [15:0] line_sel;
  logic [15:0] row_drv;

  typedef struct {
    logic [15:0] ls;
    logic [15:0] rd;
    logic        fs;
    logic        sa;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert;
  int          n_fail;
  int          m_t;
  bit          m_front;
  bit          m_pending;
  logic [15:0] m_bank [2][16];
  int          ack_seen;
  int          fs_seen;
  logic        obs_ack;
  int          t_a;
  int          a0;

  led_matrix_scan #(.LINE_CYC(LC), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_line     (wr_line),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .line_sel    (line_sel),
    .row_drv     (row_drv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_front   = 1'b0;
    m_pending = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 16; l++)
        m_bank[b][l] = 16'h0000;
  endtask

  // One clock: drive inputs at the falling edge, advance the model across the
  // rising edge, then compare DUT outputs at the next falling edge.
  task automatic tick(input logic we, input logic [3:0] wl, input logic [15:0] wd, input logic sr);
    exp_t        e;
    exp_t        g;
    int          f;
    int          ln;
    int          ps;
    bit          do_swap;
    logic [15:0] one;
    one      = 16'h0001;
    wr_en    = we;
    wr_line  = wl;
    wr_data  = wd;
    swap_req = sr;
    do_swap = (m_t >= 1) && (((m_t - 1) % FP) == FP - 1) && m_pending;
    if (we) m_bank[m_front ? 0 : 1][wl] = wd;
    if (do_swap) begin
      m_front   = ~m_front;
      m_pending = sr;
    end else begin
      m_pending = m_pending | sr;
    end
    m_t++;
    f  = (m_t - 1) % FP;
    ln = f / LP;
    ps = f % LP;
    e.ls = (ps >= BC) ? ~(one << ln) : 16'hFFFF;
    e.rd = (ps >= BC) ? m_bank[m_front ? 1 : 0][ln] : 16'h0000;
    e.fs = (ps == BC) && (ln == 0);
    e.sa = (f == FP - 1) && m_pending;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    wr_en    = 1'b0;
    swap_req = 1'b0;
    g = sb_q.pop_front();
    chk("line_sel", line_sel, g.ls);
    chk("row_drv", row_drv, g.rd);
    chk("frame_start", {15'd0, frame_start}, {15'd0, g.fs});
    chk("swap_ack", {15'd0, swap_ack}, {15'd0, g.sa});
    obs_ack = swap_ack;
    if (swap_ack === 1'b1) ack_seen++;
    if (frame_start === 1'b1) fs_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 16'h0000, 1'b0);
  endtask

  task automatic wait_ack(input string tag);
    int k;
    k = 0;
    while (obs_ack !== 1'b1 && k < 3 * FP) begin
      tick(1'b0, 4'd0, 16'h0000, 1'b0);
      k++;
    end
    chk(tag, {15'd0, obs_ack}, 16'h0001);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_line_sel"}, line_sel, 16'hFFFF);
    chk({tag, "_row_drv"}, row_drv, 16'h0000);
    chk({tag, "_swap_ack"}, {15'd0, swap_ack}, 16'h0000);
    chk({tag, "_frame_start"}, {15'd0, frame_start}, 16'h0000);
  endtask

  initial begin
    int k;
    n_assert = 0;
    n_fail   = 0;
    ack_seen = 0;
    fs_seen  = 0;
    obs_ack  = 1'b0;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_line  = 4'd0;
    wr_data  = 16'h0000;
    swap_req = 1'b0;
    model_reset();

    // Reset state, then two idle frames.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    idle(2 * FP);
    chk("frame_start_count", 16'(fs_seen), 16'd2);

    // Walking-one pattern into the back bank, then swap.
    for (int i = 0; i < 16; i++) tick(1'b1, 4'(i), 16'h0001 << i, 1'b0);
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    wait_ack("walk_swap_ack");
    chk("ack_count_1", 16'(ack_seen), 16'd1);
    idle(FP + 3);

    // Write without swap stays hidden; the swap reveals it.
    tick(1'b1, 4'd3, 16'hA5A5, 1'b0);
    idle(3 * FP);
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    wait_ack("a5_swap_ack");
    idle(FP + 5);

    // Request and write in the swap cycle itself.
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    wait_ack("pre_swap_ack");
    t_a = m_t;
    tick(1'b1, 4'd0, 16'h00FF, 1'b1);
    wait_ack("second_swap_ack");
    chk("swap_spacing", 16'(m_t - t_a), 16'(FP));

    // Three requests in one frame produce a single swap.
    a0 = ack_seen;
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    idle(10);
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    idle(10);
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    idle(2 * FP + 10);
    chk("triple_req_acks", 16'(ack_seen - a0), 16'd1);

    // Light line 7 with data, then reset in the middle of its SHOW phase.
    tick(1'b1, 4'd7, 16'h1234, 1'b1);
    wait_ack("l7_swap_ack");
    k = 0;
    while (!((((m_t - 1) % FP) / LP == 7) && (((m_t - 1) % FP) % LP == BC + 1)) && k < 2 * FP) begin
      tick(1'b0, 4'd0, 16'h0000, 1'b0);
      k++;
    end
    chk("mid_line7_row", row_drv, 16'h1234);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("held_rst");
    reset_n = 1'b1;
    model_reset();
    obs_ack = 1'b0;
    idle(FP);
    // Banks were cleared: swapping shows an all-dark frame.
    tick(1'b0, 4'd0, 16'h0000, 1'b1);
    wait_ack("post_rst_swap_ack");
    idle(FP + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
